// File: rtl/pipe_hazard_ctl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs shared between
// the datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctl_if;
    logic [4:0]  i_rs1_d;
    logic [4:0]  i_rs2_d;
    logic [4:0]  i_rs1_e;
    logic [4:0]  i_rs2_e;
    logic [4:0]  i_rd_e;
    logic [1:0]  i_result_src_e;
    logic        i_pc_src_e;
    logic [4:0]  i_rd_m;
    logic [4:0]  i_rd_w;
    logic        i_reg_wr_m;
    logic        i_reg_wr_w;
    logic        i_mem_req_m;
    logic        i_dmem_ready;
    logic        i_exception_m;

    logic        o_stall_f;
    logic        o_stall_d;
    logic        o_stall_e;
    logic        o_stall_m;
    logic        o_flush_d;
    logic        o_flush_e;
    logic        o_flush_m;
    logic        o_flush_w;
    logic [1:0]  o_fwd_a_e;
    logic [1:0]  o_fwd_b_e;
    logic        o_trap_redirect;
    logic        o_mem_timeout;
    logic [31:0] o_stall_cycles;

    modport master (
        output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_result_src_e,
               i_pc_src_e, i_rd_m, i_rd_w, i_reg_wr_m, i_reg_wr_w,
               i_mem_req_m, i_dmem_ready, i_exception_m,
        input  o_stall_f, o_stall_d, o_stall_e, o_stall_m,
               o_flush_d, o_flush_e, o_flush_m, o_flush_w,
               o_fwd_a_e, o_fwd_b_e, o_trap_redirect, o_mem_timeout,
               o_stall_cycles
    );

    modport slave (
        input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_result_src_e,
               i_pc_src_e, i_rd_m, i_rd_w, i_reg_wr_m, i_reg_wr_w,
               i_mem_req_m, i_dmem_ready, i_exception_m,
        output o_stall_f, o_stall_d, o_stall_e, o_stall_m,
               o_flush_d, o_flush_e, o_flush_m, o_flush_w,
               o_fwd_a_e, o_fwd_b_e, o_trap_redirect, o_mem_timeout,
               o_stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding,
// load-use/branch handling, data-memory wait states with timeout, trap draining.
module pipe_hazard_ctl #(
    parameter int TIMEOUT     = 16,
    parameter int TRAP_CYCLES = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    pipe_hazard_ctl_if.slave bus
);
    localparam int WaitW = $clog2(TIMEOUT) + 1;
    localparam int TrapW = $clog2(TRAP_CYCLES) + 1;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] TRAP     = 2'd2;

    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam logic [TrapW-1:0] TrapLoad = TrapW'(TRAP_CYCLES - 1);

    logic [1:0]       state_q, state_d, effState;
    logic [WaitW-1:0] waitCnt_q, waitCnt_d;
    logic [TrapW-1:0] trapCnt_q, trapCnt_d;
    logic             memTimeout_q, memTimeout_d;
    logic [31:0]      stallCycles_q;

    logic stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM, flushW;
    logic trapRedirect, loadUse;
    logic trapNow, memStall, normal;

    // MEM result wins over WB because it is the younger write; x0 never forwards.
    function automatic logic [1:0] fwdSel(input logic [4:0] rs,
                                          input logic       wrM, input logic [4:0] rdM,
                                          input logic       wrW, input logic [4:0] rdW);
        if (wrM && rdM != 5'd0 && rdM == rs)      return 2'b10;
        else if (wrW && rdW != 5'd0 && rdW == rs) return 2'b01;
        else                                      return 2'b00;
    endfunction

    assign bus.o_fwd_a_e = fwdSel(bus.i_rs1_e, bus.i_reg_wr_m, bus.i_rd_m,
                                  bus.i_reg_wr_w, bus.i_rd_w);
    assign bus.o_fwd_b_e = fwdSel(bus.i_rs2_e, bus.i_reg_wr_m, bus.i_rd_m,
                                  bus.i_reg_wr_w, bus.i_rd_w);

    always_comb begin
        effState     = i_rst ? RUN : state_q;
        loadUse      = (bus.i_result_src_e == 2'b01) && (bus.i_rd_e != 5'd0) &&
                       ((bus.i_rd_e == bus.i_rs1_d) || (bus.i_rd_e == bus.i_rs2_d));
        state_d      = effState;
        waitCnt_d    = '0;
        trapCnt_d    = '0;
        memTimeout_d = 1'b0;
        trapNow      = 1'b0;
        memStall     = 1'b0;
        normal       = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        flushW       = 1'b0;
        trapRedirect = 1'b0;

        case (effState)
            RUN: begin
                if (bus.i_exception_m) begin
                    trapNow = 1'b1;
                end else if (bus.i_mem_req_m && !bus.i_dmem_ready) begin
                    memStall  = 1'b1;
                    state_d   = MEM_WAIT;
                    waitCnt_d = WaitW'(1);
                end else begin
                    normal = 1'b1;
                end
            end
            // Once waiting, the request line is no longer consulted; only ready ends the wait.
            MEM_WAIT: begin
                if (bus.i_exception_m) begin
                    trapNow = 1'b1;
                end else if (bus.i_dmem_ready) begin
                    normal  = 1'b1;
                    state_d = RUN;
                end else if (waitCnt_q == WaitLast) begin
                    trapNow      = 1'b1;
                    memTimeout_d = 1'b1;
                end else begin
                    memStall  = 1'b1;
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            TRAP: begin
                stallF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                if (trapCnt_q == '0) state_d = RUN;
                else                 trapCnt_d = trapCnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (trapNow) begin
            flushD       = 1'b1;
            flushE       = 1'b1;
            flushM       = 1'b1;
            trapRedirect = 1'b1;
            state_d      = TRAP;
            trapCnt_d    = TrapLoad;
        end
        if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end
        if (normal) begin
            if (bus.i_pc_src_e) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (loadUse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= RUN;
            waitCnt_q     <= '0;
            trapCnt_q     <= '0;
            memTimeout_q  <= 1'b0;
            stallCycles_q <= '0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            trapCnt_q     <= trapCnt_d;
            memTimeout_q  <= memTimeout_d;
            stallCycles_q <= stallCycles_q + 32'(stallF);
        end
    end

    assign bus.o_stall_f       = stallF;
    assign bus.o_stall_d       = stallD;
    assign bus.o_stall_e       = stallE;
    assign bus.o_stall_m       = stallM;
    assign bus.o_flush_d       = flushD;
    assign bus.o_flush_e       = flushE;
    assign bus.o_flush_m       = flushM;
    assign bus.o_flush_w       = flushW;
    assign bus.o_trap_redirect = trapRedirect;
    assign bus.o_mem_timeout   = memTimeout_q;
    assign bus.o_stall_cycles  = stallCycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_pipe_hazard_ctl;
    typedef struct packed {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic [1:0] resultSrcE;
        logic       pcSrcE;
        logic [4:0] rdM, rdW;
        logic       regWrM, regWrW, memReqM, dmemReady, exceptionM;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic [1:0]  fwdA, fwdB;
        logic        redirect, timeout;
        logic [31:0] stallCycles;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam int NumVec = 16;

    logic clk;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;
    exp_t expQ[$];
    vec_t vecs[NumVec];

    pipe_hazard_ctl_if bus();

    pipe_hazard_ctl #(.TIMEOUT(16), .TRAP_CYCLES(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mkStim(input logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE,
                                     input logic [1:0] resSrc, input logic pcSrc,
                                     input logic [4:0] rdM, rdW,
                                     input logic wrM, wrW, memReq, ready, exc);
        stim_t s;
        s = '{rs1D, rs2D, rs1E, rs2E, rdE, resSrc, pcSrc, rdM, rdW,
              wrM, wrW, memReq, ready, exc};
        return s;
    endfunction

    function automatic exp_t mkExp(input logic [3:0] stall, flush,
                                   input logic [1:0] fa, fb,
                                   input logic redir, tmo, input logic [31:0] cyc);
        exp_t e;
        e = '{stall, flush, fa, fb, redir, tmo, cyc};
        return e;
    endfunction

    task automatic applyStimulus(input logic rstVal, input stim_t s, input exp_t e);
        @(negedge clk);
        rst                = rstVal;
        bus.i_rs1_d        = s.rs1D;
        bus.i_rs2_d        = s.rs2D;
        bus.i_rs1_e        = s.rs1E;
        bus.i_rs2_e        = s.rs2E;
        bus.i_rd_e         = s.rdE;
        bus.i_result_src_e = s.resultSrcE;
        bus.i_pc_src_e     = s.pcSrcE;
        bus.i_rd_m         = s.rdM;
        bus.i_rd_w         = s.rdW;
        bus.i_reg_wr_m     = s.regWrM;
        bus.i_reg_wr_w     = s.regWrW;
        bus.i_mem_req_m    = s.memReqM;
        bus.i_dmem_ready   = s.dmemReady;
        bus.i_exception_m  = s.exceptionM;
        expQ.push_back(e);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        #2;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s.queue: got empty, expected one entry", name);
        end else begin
            e = expQ.pop_front();
            cmp(name, "stall", 32'({bus.o_stall_f, bus.o_stall_d, bus.o_stall_e, bus.o_stall_m}), 32'(e.stall));
            cmp(name, "flush", 32'({bus.o_flush_d, bus.o_flush_e, bus.o_flush_m, bus.o_flush_w}), 32'(e.flush));
            cmp(name, "fwdA", 32'(bus.o_fwd_a_e), 32'(e.fwdA));
            cmp(name, "fwdB", 32'(bus.o_fwd_b_e), 32'(e.fwdB));
            cmp(name, "redirect", 32'(bus.o_trap_redirect), 32'(e.redirect));
            cmp(name, "timeout", 32'(bus.o_mem_timeout), 32'(e.timeout));
            cmp(name, "stallCycles", bus.o_stall_cycles, e.stallCycles);
        end
    endtask

    task automatic resetCycle();
        @(negedge clk);
        rst = 1'b1;
        bus.i_mem_req_m   = 1'b0;
        bus.i_exception_m = 1'b0;
        bus.i_pc_src_e    = 1'b0;
    endtask

    initial begin
        stim_t idle, memWait, mw;

        idle    = mkStim(0,0,0,0,0,2'b00,0,0,0,0,0,0,1,0);
        memWait = mkStim(0,0,0,0,0,2'b00,0,0,0,0,0,1,0,0);

        // rs1D rs2D rs1E rs2E rdE resSrc pcSrc rdM rdW wrM wrW memReq ready exc
        vecs[0]  = '{idle,                                             mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};
        vecs[1]  = '{mkStim(5,0,0,0,5,2'b01,0,0,0,0,0,0,1,0),          mkExp(4'hC,4'h4,2'b00,2'b00,0,0,0)};
        vecs[2]  = '{mkStim(0,9,0,0,9,2'b01,0,0,0,0,0,0,1,0),          mkExp(4'hC,4'h4,2'b00,2'b00,0,0,0)};
        vecs[3]  = '{mkStim(0,0,0,0,0,2'b01,0,0,0,0,0,0,1,0),          mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};
        vecs[4]  = '{mkStim(5,0,0,0,5,2'b10,0,0,0,0,0,0,1,0),          mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};
        vecs[5]  = '{mkStim(0,0,7,0,0,2'b00,0,7,7,1,1,0,1,0),          mkExp(4'h0,4'h0,2'b10,2'b00,0,0,0)};
        vecs[6]  = '{mkStim(0,0,7,0,0,2'b00,0,7,7,0,1,0,1,0),          mkExp(4'h0,4'h0,2'b01,2'b00,0,0,0)};
        vecs[7]  = '{mkStim(0,0,3,7,0,2'b00,0,7,3,1,1,0,1,0),          mkExp(4'h0,4'h0,2'b01,2'b10,0,0,0)};
        vecs[8]  = '{mkStim(0,0,0,0,0,2'b00,0,0,0,1,1,0,1,0),          mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};
        vecs[9]  = '{mkStim(5,0,0,0,5,2'b01,1,0,0,0,0,0,1,0),          mkExp(4'h0,4'hC,2'b00,2'b00,0,0,0)};
        vecs[10] = '{mkStim(5,0,0,0,5,2'b01,1,0,0,0,0,0,1,1),          mkExp(4'h0,4'hE,2'b00,2'b00,1,0,0)};
        vecs[11] = '{memWait,                                          mkExp(4'hF,4'h1,2'b00,2'b00,0,0,0)};
        vecs[12] = '{mkStim(0,0,0,0,0,2'b00,0,0,0,0,0,1,1,0),          mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};
        vecs[13] = '{mkStim(0,0,0,0,0,2'b00,0,0,0,0,0,1,0,1),          mkExp(4'h0,4'hE,2'b00,2'b00,1,0,0)};
        vecs[14] = '{mkStim(5,0,0,0,5,2'b01,1,0,0,0,0,1,0,0),          mkExp(4'hF,4'h1,2'b00,2'b00,0,0,0)};
        vecs[15] = '{mkStim(0,0,7,7,0,2'b00,0,7,7,0,0,0,1,0),          mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0)};

        rst = 1'b1;
        bus.i_rs1_d = '0; bus.i_rs2_d = '0; bus.i_rs1_e = '0; bus.i_rs2_e = '0;
        bus.i_rd_e = '0; bus.i_result_src_e = '0; bus.i_pc_src_e = 1'b0;
        bus.i_rd_m = '0; bus.i_rd_w = '0; bus.i_reg_wr_m = 1'b0; bus.i_reg_wr_w = 1'b0;
        bus.i_mem_req_m = 1'b0; bus.i_dmem_ready = 1'b1; bus.i_exception_m = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] reset checks");
        applyStimulus(1'b1, idle, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0));
        checkOutput("resetIdle");
        applyStimulus(1'b1, vecs[1].s, mkExp(4'hC,4'h4,2'b00,2'b00,0,0,0));
        checkOutput("resetRunView");

        $display("[TB] table vectors");
        for (int i = 0; i < NumVec; i++) begin
            applyStimulus(1'b0, vecs[i].s, vecs[i].e);
            checkOutput($sformatf("vec%0d", i));
            resetCycle();
        end

        $display("[TB] memory wait of three cycles");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, memWait, mkExp(4'hF,4'h1,2'b00,2'b00,0,0,32'(k)));
            checkOutput($sformatf("wait3_c%0d", k));
        end
        mw = memWait; mw.dmemReady = 1'b1;
        applyStimulus(1'b0, mw, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,3));
        checkOutput("wait3_ready");
        mw = memWait; mw.memReqM = 1'b0;
        applyStimulus(1'b0, mw, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,3));
        checkOutput("wait3_backInRun");
        resetCycle();

        $display("[TB] memory timeout");
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, memWait, mkExp(4'hF,4'h1,2'b00,2'b00,0,0,32'(k)));
            checkOutput($sformatf("tmo_c%0d", k));
        end
        applyStimulus(1'b0, memWait, mkExp(4'h0,4'hE,2'b00,2'b00,1,0,15));
        checkOutput("tmo_redirect");
        applyStimulus(1'b0, memWait, mkExp(4'h8,4'hC,2'b00,2'b00,0,1,15));
        checkOutput("tmo_trap1");
        mw = memWait; mw.exceptionM = 1'b1;
        applyStimulus(1'b0, mw, mkExp(4'h8,4'hC,2'b00,2'b00,0,0,16));
        checkOutput("tmo_trap2");
        mw = memWait; mw.memReqM = 1'b0;
        applyStimulus(1'b0, mw, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,17));
        checkOutput("tmo_backInRun");
        resetCycle();

        $display("[TB] reset during memory wait");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, memWait, mkExp(4'hF,4'h1,2'b00,2'b00,0,0,32'(k)));
            checkOutput($sformatf("rstWait_c%0d", k));
        end
        applyStimulus(1'b1, memWait, mkExp(4'hF,4'h1,2'b00,2'b00,0,0,2));
        checkOutput("rstWait_inReset");
        mw = memWait; mw.memReqM = 1'b0;
        applyStimulus(1'b0, mw, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0));
        checkOutput("rstWait_after");
        resetCycle();

        $display("[TB] reset during trap");
        mw = idle; mw.exceptionM = 1'b1;
        applyStimulus(1'b0, mw, mkExp(4'h0,4'hE,2'b00,2'b00,1,0,0));
        checkOutput("rstTrap_enter");
        applyStimulus(1'b1, idle, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0));
        checkOutput("rstTrap_inReset");
        applyStimulus(1'b0, idle, mkExp(4'h0,4'h0,2'b00,2'b00,0,0,0));
        checkOutput("rstTrap_after");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
